rgb_led_driver: RTL and testbench
=================================

Name: rgb_led_driver

Overview:
- Downstream stage of the 4-input colour decoder. It consumes the decoder's R/G/B levels and drives three physical LED channels.
- Filters glitches on the combinational R/G/B inputs by requiring them to be stable for STABLE_CYCLES clocks.
- Applies the accepted colour with a brightness PWM.
- Colour and brightness updates take effect only at PWM period boundaries, so the LED never shows a partial period.

Parameters:
- CNT_W, 8: PWM counter width; period = 2**CNT_W clocks.
- STABLE_CYCLES, 4: consecutive identical input samples required before a colour is accepted; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- r_in  input  1  red level from the colour decoder (synchronous to clk).
- g_in  input  1  green level from the colour decoder.
- b_in  input  1  blue level from the colour decoder.
- brightness  input  CNT_W  PWM duty, sampled once per period.
- led_r  output  1  red LED drive.
- led_g  output  1  green LED drive.
- led_b  output  1  blue LED drive.
- period_start  output  1  high while pwm_cnt == 0.
- color_changed  output  1  one-cycle pulse when the applied colour takes a new value.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. rst_n low immediately clears every flop:
  - cand, cnt, stable_color, color_q, pwm_cnt, duty_q, color_changed all = 0.
  - Result: led_* = 0, period_start = 1, color_changed = 0.
  - The first clock after rst_n rises behaves as a normal cycle.
- Glitch filter (per clock):
  - in = {r_in, g_in, b_in}.
  - If in != cand: cand <= in, cnt <= 0.
  - Else if cnt != STABLE_CYCLES-1: cnt <= cnt+1; otherwise cnt saturates.
  - When cnt == STABLE_CYCLES-1: stable_color <= cand.
- Filter latency: an input first sampled at edge t (and held) reaches stable_color at edge t+STABLE_CYCLES. Any pulse shorter than STABLE_CYCLES samples is ignored entirely.
- PWM counter: pwm_cnt increments every clock and wraps from 2**CNT_W-1 to 0.
- Period-boundary update: on the edge where pwm_cnt == 2**CNT_W-1:
  - duty_q <= brightness;
  - color_q <= stable_color;
  - color_changed <= (stable_color != color_q).
  - On every other edge, color_changed <= 0.
- Outputs:
  - led_r = color_q[2] & (pwm_cnt < duty_q); likewise led_g uses bit 1 and led_b uses bit 0.
  - Outputs are decoded from flops only; there is no combinational path from any input to any output.
- Duty bounds:
  - duty_q = 0 gives a constant off.
  - duty_q = 2**CNT_W-1 gives on for all but the last clock of each period. Full-on is deliberately not reachable.
- Mid-period changes:
  - brightness changes mid-period are ignored until the wrap.
  - A stable_color update mid-period is held until the wrap.
  - If stable_color changes twice within one period, only the value present at the wrap is applied.
- Simultaneous events: a filter acceptance on the wrap edge itself is not seen by color_q until the next wrap, because color_q samples the pre-edge stable_color.
- Reset mid-operation: outputs drop to 0 asynchronously. Filter history is discarded; a new colour needs the full STABLE_CYCLES plus a period boundary.

Decomposition:
- Package rgb_pkg:
  - typedef struct packed {logic r, g, b;} rgb_t;
  - RGB_OFF = '0.
  - Used for cand, stable_color and color_q.
- Sub-module rgb_glitch_filter:
  - Parameter STABLE_CYCLES.
  - Ports: clk, rst_n, rgb_t in, rgb_t stable.
  - Contains the cand/cnt/stable_color logic.
  - Reused for the button inputs upstream of the decoder.

Test Plan:
All scenarios use CNT_W=4 and STABLE_CYCLES=4.
1. Reset: rst_n=0 asserted asynchronously mid-simulation -> led_r/g/b=0 and color_changed=0 with no clock edge; period_start=1.
2. Basic colour: release reset, rgb_in=100, brightness=8 held -> color_changed pulses once at the first wrap after edge 4. Thereafter each 16-cycle period has led_r=1 for pwm_cnt 0..7 and 0 for 8..15; led_g=led_b=0.
3. Glitch rejection: after steady 100, drive 010 for 3 clocks then return to 100 -> stable_color and color_q stay 100 and color_changed never pulses. Driving 010 for 4 clocks changes stable_color, applied at the next wrap.
4. Duty bounds: brightness=0 -> all LEDs off for a whole period. brightness=15 with rgb=111 -> all three on for 15 of 16 cycles, off at pwm_cnt=15.
5. Mid-period change: at pwm_cnt=5 change brightness 8->2 -> the current period still runs with duty 8; the next period has duty 2 (on for pwm_cnt 0..1).
6. Wrap-edge acceptance: time the filter acceptance onto the edge where pwm_cnt=15 -> color_q is unchanged for the following period and updates one period later.

Source files
------------

// File: rtl/rgb_pkg.sv
// Shared colour types for the RGB LED path: colour-triple struct and helpers.
package rgb_pkg;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_t;

    localparam rgb_t RGB_OFF = rgb_t'(3'b000);

    // Gate every channel of a colour with a single enable (the PWM "on" phase).
    function automatic rgb_t rgb_mask(input rgb_t color, input logic enable);
        rgb_t result;
        result.r = color.r & enable;
        result.g = color.g & enable;
        result.b = color.b & enable;
        return result;
    endfunction

endpackage

// File: rtl/rgb_glitch_filter.sv
// Accepts a colour only after it has been sampled unchanged for STABLE_CYCLES clocks.
module rgb_glitch_filter
    import rgb_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  rgb_t in,
    output rgb_t stable
);

    localparam int CNT_BITS = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(STABLE_CYCLES - 1);

    rgb_t                cand_r;
    rgb_t                stable_r;
    logic [CNT_BITS-1:0] cnt_r;

    // Candidate tracking with a saturating run-length counter; a new value restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_r <= RGB_OFF;
            cnt_r  <= CNT_BITS'(0);
        end else if (in != cand_r) begin
            cand_r <= in;
            cnt_r  <= CNT_BITS'(0);
        end else if (cnt_r != CNT_LAST) begin
            cand_r <= cand_r;
            cnt_r  <= cnt_r + CNT_BITS'(1);
        end else begin
            cand_r <= cand_r;
            cnt_r  <= cnt_r;
        end
    end

    // Promote the candidate once its run has reached the required length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_r <= RGB_OFF;
        end else if (cnt_r == CNT_LAST) begin
            stable_r <= cand_r;
        end else begin
            stable_r <= stable_r;
        end
    end

    assign stable = stable_r;

endmodule

// File: rtl/rgb_led_driver.sv
// Filters decoder colour levels and drives three LED channels with a brightness PWM,
// updating colour and duty only at PWM period boundaries.
module rgb_led_driver
    import rgb_pkg::*;
#(
    parameter int CNT_W         = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r_in,
    input  logic             g_in,
    input  logic             b_in,
    input  logic [CNT_W-1:0] brightness,
    output logic             led_r,
    output logic             led_g,
    output logic             led_b,
    output logic             period_start,
    output logic             color_changed
);

    localparam logic [CNT_W-1:0] PWM_LAST = {CNT_W{1'b1}};

    rgb_t             in_s;
    rgb_t             stable_s;
    rgb_t             drive_s;
    rgb_t             color_q_r;
    logic [CNT_W-1:0] pwm_cnt_r;
    logic [CNT_W-1:0] duty_q_r;
    logic             color_changed_r;
    logic             wrap_s;
    logic             on_s;

    // Pack the decoder levels into the colour struct.
    always_comb begin
        in_s   = RGB_OFF;
        in_s.r = r_in;
        in_s.g = g_in;
        in_s.b = b_in;
    end

    rgb_glitch_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .in     (in_s),
        .stable (stable_s)
    );

    // Free-running PWM counter; wraps naturally at its width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_r <= CNT_W'(0);
        end else begin
            pwm_cnt_r <= pwm_cnt_r + CNT_W'(1);
        end
    end

    assign wrap_s = (pwm_cnt_r == PWM_LAST);

    // Capture duty and colour on the wrap edge so a period is never shown half-updated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q_r        <= CNT_W'(0);
            color_q_r       <= RGB_OFF;
            color_changed_r <= 1'b0;
        end else if (wrap_s) begin
            duty_q_r        <= brightness;
            color_q_r       <= stable_s;
            color_changed_r <= (stable_s != color_q_r);
        end else begin
            duty_q_r        <= duty_q_r;
            color_q_r       <= color_q_r;
            color_changed_r <= 1'b0;
        end
    end

    // Decode LED drive from flops only; the max duty deliberately leaves the last clock dark.
    always_comb begin
        on_s    = (pwm_cnt_r < duty_q_r);
        drive_s = rgb_mask(color_q_r, on_s);
    end

    assign led_r         = drive_s.r;
    assign led_g         = drive_s.g;
    assign led_b         = drive_s.b;
    assign period_start  = (pwm_cnt_r == CNT_W'(0));
    assign color_changed = color_changed_r;

endmodule

// File: tb/tb_rgb_led_driver.sv
// Randomised and directed bench for rgb_led_driver against a behavioural colour/PWM model.
module tb_rgb_led_driver;

    localparam int CNT_W = 4;
    localparam int SC    = 4;
    localparam int PER   = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             r_in = 1'b0;
    logic             g_in = 1'b0;
    logic             b_in = 1'b0;
    logic [CNT_W-1:0] brightness = 4'd0;
    logic             led_r, led_g, led_b, period_start, color_changed;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    // Model state: last input samples, accepted colour, applied colour/duty, PWM phase.
    logic [2:0] hist[$];
    logic [2:0] m_stable;
    logic [2:0] m_color;
    int         m_pwm;
    int         m_duty;
    bit         m_chg;

    always #5 clk = ~clk;

    rgb_led_driver #(.CNT_W(CNT_W), .STABLE_CYCLES(SC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .r_in          (r_in),
        .g_in          (g_in),
        .b_in          (b_in),
        .brightness    (brightness),
        .led_r         (led_r),
        .led_g         (led_g),
        .led_b         (led_b),
        .period_start  (period_start),
        .color_changed (color_changed)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_stable = 3'b000;
        m_color  = 3'b000;
        m_pwm    = 0;
        m_duty   = 0;
        m_chg    = 1'b0;
    endtask

    function automatic logic [4:0] model_out();
        logic on;
        on = (m_pwm < m_duty);
        return {m_color[2] & on, m_color[1] & on, m_color[0] & on, m_pwm == 0, m_chg};
    endfunction

    task automatic set_rgb(input logic [2:0] v);
        {r_in, g_in, b_in} = v;
    endtask

    // One clock: advance the model by the rules, then compare all outputs.
    task automatic step(input string tag);
        logic [2:0] s;
        logic [2:0] ns;
        int         b;
        bit         all_eq;
        @(posedge clk);
        s  = {r_in, g_in, b_in};
        b  = int'(brightness);
        ns = m_stable;
        if (hist.size() == SC) begin
            all_eq = 1'b1;
            for (int i = 0; i < SC; i++)
                if (hist[i] != hist[0]) all_eq = 1'b0;
            if (all_eq) ns = hist[0];
        end
        hist.push_back(s);
        if (hist.size() > SC) void'(hist.pop_front());
        if (m_pwm == PER - 1) begin
            m_chg   = (m_stable != m_color);
            m_color = m_stable;
            m_duty  = b;
        end else begin
            m_chg = 1'b0;
        end
        m_stable = ns;
        m_pwm    = (m_pwm + 1) % PER;
        #1;
        check_val(tag, {27'd0, led_r, led_g, led_b, period_start, color_changed}, {27'd0, model_out()});
        if (color_changed === 1'b1) pulses++;
    endtask

    task automatic run_to(input int target, input string tag);
        int n;
        n = (target - m_pwm + PER) % PER;
        repeat (n) step(tag);
    endtask

    // Reset asynchronously between edges and check outputs before any clock.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_val(tag, {27'd0, led_r, led_g, led_b, period_start, color_changed}, 32'h0000_0002);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_val("reset_init", {27'd0, led_r, led_g, led_b, period_start, color_changed}, 32'h0000_0002);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic colour: red at half duty.
        pulses = 0;
        set_rgb(3'b100);
        brightness = 4'd8;
        repeat (2 * PER) step("s2_run");
        for (int k = 0; k < PER; k++) begin
            check_val("s2_led", {29'd0, led_r, led_g, led_b}, (k < 8) ? 32'd4 : 32'd0);
            step("s2_run");
        end
        check_val("s2_pulses", pulses, 32'd1);

        // Short glitch ignored, held change accepted.
        pulses = 0;
        set_rgb(3'b010);
        repeat (3) step("s3_glitch");
        set_rgb(3'b100);
        repeat (2 * PER) step("s3_run");
        check_val("s3_no_pulse", pulses, 32'd0);
        set_rgb(3'b010);
        repeat (2 * PER) step("s3_change");
        check_val("s3_one_pulse", pulses, 32'd1);

        // Duty bounds.
        brightness = 4'd0;
        step("s4_zero");
        run_to(0, "s4_zero");
        for (int k = 0; k < PER; k++) begin
            check_val("s4_off", {29'd0, led_r, led_g, led_b}, 32'd0);
            step("s4_zero");
        end
        set_rgb(3'b111);
        brightness = 4'd15;
        step("s4_full");
        run_to(0, "s4_full");
        step("s4_full");
        run_to(0, "s4_full");
        for (int k = 0; k < PER; k++) begin
            check_val("s4_max", {29'd0, led_r, led_g, led_b}, (k < 15) ? 32'd7 : 32'd0);
            step("s4_full");
        end

        // Mid-period brightness change takes effect only after the wrap.
        brightness = 4'd8;
        step("s5_run");
        run_to(0, "s5_run");
        run_to(5, "s5_run");
        brightness = 4'd2;
        run_to(0, "s5_run");
        for (int k = 0; k < PER; k++) begin
            check_val("s5_duty2", {29'd0, led_r, led_g, led_b}, (k < 2) ? 32'd7 : 32'd0);
            step("s5_run");
        end

        // Acceptance on the wrap edge is applied one period later.
        run_to(11, "s6_run");
        set_rgb(3'b001);
        repeat (5) step("s6_run");
        check_val("s6_no_early", {31'd0, color_changed}, 32'd0);
        repeat (PER) step("s6_run");
        check_val("s6_late", {31'd0, color_changed}, 32'd1);

        // Random colours with random hold lengths, brightness and a mid-run reset.
        for (int seg = 0; seg < 120; seg++) begin
            set_rgb(3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) brightness = 4'($urandom_range(0, 15));
            repeat ($urandom_range(1, 6)) step("rand");
            if (seg == 60) async_reset("reset_mid");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
